// File: rtl/serial_adder_4.sv
// Bit-serial adder: captures two WIDTH-bit operands and a carry-in, adds one bit
// per clock through a half-adder pair, then presents sum, carry-out and overflow.
module serial_adder_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic ai, bi, s1, c1, sum, c2, c_next;

  // Full-adder bit built from two half-adder stages.
  always_comb begin
    ai     = a_r[cnt];
    bi     = b_r[cnt];
    s1     = ai ^ bi;
    c1     = ai & bi;
    sum    = s1 ^ carry;
    c2     = s1 & carry;
    c_next = c1 | c2;
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; in_ready is high only in IDLE and out_valid only in DONE, so the
  // input and output transfers never overlap.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      q     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            carry <= cin;
            cnt   <= '0;
            q     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          q[cnt] <= sum;
          carry  <= c_next;
          // The counter parks on the last bit instead of wrapping.
          if (cnt == LAST) begin
            cout  <= c_next;
            ovf   <= carry ^ c_next;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_4.sv
// Directed and randomized checks of serial_adder_4 against an arithmetic model
// of unsigned/signed addition, including backpressure and mid-operation reset.
module tb_serial_adder_4;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] q;
  logic         cout;
  logic         ovf;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  serial_adder_4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: integer sums, unsigned for q/cout, signed range test for ovf.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc);
    int usum, sa, sb, ssum;
    logic [W-1:0] mq;
    logic mco, mov;
    usum = int'(ma) + int'(mb) + int'(mc);
    mq   = W'(usum % (1 << W));
    mco  = (usum >= (1 << W));
    sa   = (int'(ma) >= (1 << (W - 1))) ? int'(ma) - (1 << W) : int'(ma);
    sb   = (int'(mb) >= (1 << (W - 1))) ? int'(mb) - (1 << W) : int'(mb);
    ssum = sa + sb + int'(mc);
    mov  = (ssum > (1 << (W - 1)) - 1) || (ssum < -(1 << (W - 1)));
    return {mov, mco, mq};
  endfunction

  // Driver: one full operation with optional noise during RUN and hold cycles in DONE.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic [W-1:0] eq, input logic ec, input logic eo,
                        input int hold, input bit noisy);
    int  lat;
    bit  seen;
    check("in_ready_before_accept", in_ready, 1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 4 * W + 8; i++) begin
      if (out_valid) begin
        seen = 1;
        break;
      end
      if (noisy) begin
        in_valid  = 1'($urandom_range(0, 1));
        a         = W'($urandom);
        b         = W'($urandom);
        cin       = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
      end
      tick;
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL timeout: out_valid never rose within %0d cycles", 4 * W + 8);
      return;
    end
    check("latency", lat, W);
    check("in_ready_in_done", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      tick;
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_q", q, eq);
    end
    check("q", q, eq);
    check("cout", cout, ec);
    check("ovf", ovf, eo);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("out_valid_after_handshake", out_valid, 0);
    check("in_ready_after_handshake", in_ready, 1);
    check("q_kept_in_idle", q, eq);
  endtask

  task automatic run_random(input int hold, input bit noisy);
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W+1:0] m;
    ra = W'($urandom);
    rb = W'($urandom);
    rc = 1'($urandom_range(0, 1));
    m  = model(ra, rb, rc);
    run_op(ra, rb, rc, m[W-1:0], m[W], m[W+1], hold, noisy);
  endtask

  initial begin
    rst_n     = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_q", q, 0);
    check("reset_cout", cout, 0);
    check("reset_ovf", ovf, 0);
    check("reset_state", dbg_state, 0);
    rst_n = 1'b1;
    tick;
    tick;
    check("idle_hold_in_ready", in_ready, 1);

    // Directed vectors
    run_op(4'd3,  4'd5,  1'b0, 4'd8,  1'b0, 1'b1, 0, 1'b0);
    run_op(4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0, 0, 1'b0);
    run_op(4'd8,  4'd15, 1'b0, 4'd7,  1'b1, 1'b1, 0, 1'b0);
    run_op(4'd0,  4'd0,  1'b1, 4'd1,  1'b0, 1'b0, 0, 1'b0);
    // Backpressure for three cycles in DONE
    run_op(4'd9,  4'd4,  1'b1, 4'd14, 1'b0, 1'b0, 3, 1'b0);
    // in_valid and operands toggled during RUN
    run_op(4'd7,  4'd7,  1'b0, 4'd14, 1'b0, 1'b1, 1, 1'b1);

    // Reset mid-RUN after two bits
    a = 4'd5; b = 4'd9; cin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    check("mid_run_busy", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_q", q, 0);
    #2 rst_n = 1'b1;
    tick;
    check("post_reset_idle", in_ready, 1);
    run_op(4'd6, 4'd7, 1'b0, 4'd13, 1'b0, 1'b1, 0, 1'b0);

    // Randomized operations with random backpressure and RUN noise
    for (int n = 0; n < 24; n++) begin
      run_random($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) tick;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_4.md
SERIAL_ADDER_4 -- requirements
Module: serial_adder_4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port a, input, WIDTH bits: addend A, unsigned or two's complement.
REQ-005 The block SHALL have port b, input, WIDTH bits: addend B.
REQ-006 The block SHALL have port cin, input, 1 bit: carry-in to bit 0.
REQ-007 The block SHALL have port in_valid, input, 1 bit: a, b and cin are valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-009 The block SHALL have port q, output, WIDTH bits: the sum.
REQ-010 The block SHALL have port cout, output, 1 bit: carry out of the MSB.
REQ-011 The block SHALL have port ovf, output, 1 bit: two's-complement overflow.
REQ-012 The block SHALL have port out_valid, output, 1 bit: q, cout and ovf are valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, RUN and DONE, and SHALL be in IDLE after reset.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both outputs SHALL be registered or decoded from the state only.
REQ-016 In IDLE, on an edge with in_valid=1, the block SHALL capture a, b and cin into internal registers, clear the bit counter and q, and move to RUN.
REQ-017 In IDLE with in_valid=0, the block SHALL hold state and keep q, cout and ovf at their previous values.
REQ-018 In RUN, each edge SHALL process exactly one bit i (i = counter, starting at 0): q[i] = a[i] ^ b[i] ^ c and c_next = majority(a[i], b[i], c), where c starts at cin.
REQ-019 The bit processing SHALL be a full-adder bit implemented as two half-adder stages, with carry = c1 | c2.
REQ-020 On the edge that processes bit WIDTH-1, the block SHALL set cout = c_next and ovf = c ^ c_next (carry into the MSB XOR carry out of the MSB), and move to DONE.
REQ-021 Latency: with an input handshake at edge k, out_valid SHALL first be 1 in the cycle after edge k+WIDTH (exactly WIDTH RUN cycles).
REQ-022 In RUN, in_valid SHALL be ignored and the operand registers SHALL NOT change.
REQ-023 In DONE, q, cout and ovf SHALL remain stable until the output handshake (out_valid & out_ready) occurs.
REQ-024 On the output handshake edge, the block SHALL return to IDLE, and in_ready SHALL be 1 in the next cycle.
REQ-025 Input and output handshakes SHALL NOT overlap; there is no back-to-back throughput beyond one operation per WIDTH+2 cycles minimum.
REQ-026 The bit counter SHALL be ceil(log2(WIDTH)) bits wide, SHALL NOT wrap during RUN, and SHALL be cleared on entry to RUN.
REQ-027 out_ready SHALL have no effect outside DONE.
REQ-028 The arithmetic SHALL be mod 2^WIDTH; cout SHALL be the unsigned carry, and ovf SHALL be valid for signed interpretation.

Reset
REQ-029 Assertion of rst_n=0 SHALL immediately, without waiting for a clock edge, force state IDLE, q=0, cout=0, ovf=0, counter=0 and carry=0, giving in_ready=1 and out_valid=0.
REQ-030 Reset asserted in RUN or DONE SHALL abort the operation with no result delivered.
REQ-031 After rst_n deasserts, the first operand accept SHALL occur at the first rising edge with in_valid=1.

Verification
REQ-032 A bench SHALL check: WIDTH=4, a=3, b=5, cin=0 -> q=8, cout=0, ovf=1, with out_valid exactly 4 cycles after accept.
REQ-033 A bench SHALL check: a=15, b=1, cin=0 -> q=0, cout=1, ovf=0.
REQ-034 A bench SHALL check: a=8, b=15, cin=0 -> q=7, cout=1, ovf=1; and a=0, b=0, cin=1 -> q=1, cout=0, ovf=0.
REQ-035 A bench SHALL check backpressure: out_ready held at 0 for 3 cycles in DONE -> out_valid stays 1, q is unchanged and in_ready is 0; after out_ready=1, in_ready=1 in the next cycle.
REQ-036 A bench SHALL check: in_valid toggled during RUN -> no new capture and the result matches the first operands.
REQ-037 A bench SHALL check: rst_n pulsed low mid-RUN (after 2 bits) -> immediately in_ready=1, out_valid=0, q=0; a subsequent 6+7 gives q=13, cout=0, ovf=1.
